// File: rtl/ps_bigreg_assembler_pkg.sv
// ps_bigreg_assembler_pkg: memory-map layout constants and
// shared types for the PS_BIGREG span assemblers.
package ps_bigreg_assembler_pkg;

  localparam int MEM_SIZE      = 256;
  localparam int MEM_ID_W      = $clog2(MEM_SIZE);
  localparam int WD_DATA_WIDTH = 16;

  localparam int CHAN_MUX_BASE_ID = 30;
  localparam int CHAN_MUX_SAMPLES = 2;
  localparam int SDC_BASE_ID      = 33;
  localparam int SDC_SAMPLES      = 16;
  localparam int PS_SEED_BASE_ID  = 50;
  localparam int PS_SEED_SAMPLES  = 16;

  typedef enum logic [1:0] {
    COLLECT,
    HOLD,
    CLEAR
  } bigreg_state_e;

  // The VALID entry sits right after the data words.
  function automatic int valid_id(
    input int base,
    input int samples
  );
    return base + samples;
  endfunction

endpackage

// File: rtl/ps_bigreg_assembler_if.sv
// ps_bigreg_assembler_if: mem-map write port, wide-word
// handshake and freshbit-clear bundle.
interface ps_bigreg_assembler_if
  import ps_bigreg_assembler_pkg::*;
#(
  parameter int SAMPLES  = SDC_SAMPLES,
  parameter int SAMPLE_W = WD_DATA_WIDTH,
  parameter int ID_W     = MEM_ID_W
);

  logic                        wr_en;
  logic [ID_W-1:0]             wr_id;
  logic [SAMPLE_W-1:0]         wr_data;
  logic [SAMPLES*SAMPLE_W-1:0] data_out;
  logic                        data_valid;
  logic                        data_ready;
  logic                        clr_en;
  logic [ID_W-1:0]             clr_id;

  modport master (
    output wr_en,
    output wr_id,
    output wr_data,
    input  data_out,
    input  data_valid,
    output data_ready,
    input  clr_en,
    input  clr_id
  );

  modport slave (
    input  wr_en,
    input  wr_id,
    input  wr_data,
    output data_out,
    output data_valid,
    input  data_ready,
    output clr_en,
    output clr_id
  );

endinterface

// File: rtl/ps_bigreg_assembler.sv
// ps_bigreg_assembler: gathers a PS_BIGREG span into one wide
// word, hands it off, then walks the span's freshbit clears.
module ps_bigreg_assembler
  import ps_bigreg_assembler_pkg::*;
#(
  parameter int BASE_ID  = SDC_BASE_ID,
  parameter int SAMPLES  = SDC_SAMPLES,
  parameter int SAMPLE_W = WD_DATA_WIDTH,
  parameter int ID_W     = MEM_ID_W
)(
  input  logic                  clk,
  input  logic                  rst_n,
  ps_bigreg_assembler_if.slave  bus,
  output logic                  err,
  output logic                  dropped
);

  localparam int SW = (SAMPLES > 1) ?
                      $clog2(SAMPLES) : 1;
  localparam int CW = $clog2(SAMPLES + 1);

  localparam logic [ID_W-1:0] LO =
    ID_W'(BASE_ID);
  localparam logic [ID_W-1:0] VID =
    ID_W'(valid_id(BASE_ID, SAMPLES));
  localparam logic [ID_W-1:0] NS =
    ID_W'(SAMPLES);
  localparam logic [CW-1:0] LAST =
    CW'(SAMPLES);

  bigreg_state_e state;

  logic [SAMPLES-1:0][SAMPLE_W-1:0] shadow;
  logic [SAMPLES-1:0]               mask;
  logic [CW-1:0]                    cnt;
  logic [CW-1:0]                    cnt_nx;
  logic [ID_W-1:0]                  off;
  logic [SW-1:0]                    slot;
  logic                             in_span;
  logic                             is_valid;

  // Unsigned wrap pushes ids below BASE_ID out of range,
  // so the slot index never aliases.
  assign off      = bus.wr_id - LO;
  assign in_span  = bus.wr_en && (off < NS);
  assign is_valid = bus.wr_en && (bus.wr_id == VID);
  assign slot     = off[SW-1:0];
  assign cnt_nx   = cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= COLLECT;
      shadow         <= '0;
      mask           <= '0;
      cnt            <= '0;
      bus.data_out   <= '0;
      bus.data_valid <= 1'b0;
      bus.clr_en     <= 1'b0;
      bus.clr_id     <= '0;
      err            <= 1'b0;
      dropped        <= 1'b0;
    end else begin
      err <= 1'b0;
      if ((in_span || is_valid) &&
          (state != COLLECT))
        dropped <= 1'b1;
      unique case (state)
        COLLECT: begin
          if (in_span) begin
            shadow[slot] <= bus.wr_data;
            mask[slot]   <= 1'b1;
          end else if (is_valid) begin
            mask <= '0;
            if (&mask) begin
              bus.data_out   <= shadow;
              bus.data_valid <= 1'b1;
              state          <= HOLD;
            end else begin
              err        <= 1'b1;
              bus.clr_en <= 1'b1;
              bus.clr_id <= LO;
              cnt        <= '0;
              state      <= CLEAR;
            end
          end
        end
        HOLD: begin
          if (bus.data_ready) begin
            bus.data_valid <= 1'b0;
            bus.clr_en     <= 1'b1;
            bus.clr_id     <= LO;
            cnt            <= '0;
            state          <= CLEAR;
          end
        end
        CLEAR: begin
          if (cnt == LAST) begin
            bus.clr_en <= 1'b0;
            bus.clr_id <= '0;
            cnt        <= '0;
            state      <= COLLECT;
          end else begin
            cnt        <= cnt_nx;
            bus.clr_id <= LO + ID_W'(cnt_nx);
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/ps_bigreg_assembler.md
# ps_bigreg_assembler

Collects the individual 16-bit memory-map words that the processor writes to a PS_BIGREG span (e.g. SDC base..base+15, CHAN_MUX base..base+1, seed base..base+15). When the span's VALID address is written, it presents the assembled wide word to the consuming RTL block with a valid/ready handshake. After the consumer accepts the word, it sequences freshbit-clear requests back to the memory map so that the span is re-armed for the next processor update. One instance sits between the AXI memory map and each wide-register consumer (sample discriminator, channel mux, seed loader).

## Interface
Parameters:
- BASE_ID, default 33 (SDC_BASE_ID): first mem-map index of the span.
- SAMPLES, default 16 (SDC_SAMPLES): number of data words in the span. The VALID index is BASE_ID+SAMPLES.
- SAMPLE_W, default 16 (WD_DATA_WIDTH): width of each word.
- ID_W, default 8 ($clog2(MEM_SIZE)): width of a mem-map index.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  single-cycle pulse: the processor wrote a mem-map entry
- wr_id  in  ID_W  index written
- wr_data  in  SAMPLE_W  data written
- data_out  out  SAMPLES*SAMPLE_W  assembled word; the word from BASE_ID+k sits at [k*SAMPLE_W +: SAMPLE_W]
- data_valid  out  1  data_out is held for the consumer
- data_ready  in  1  consumer accepts the word
- clr_en  out  1  freshbit-clear request to the memory map
- clr_id  out  ID_W  index to clear
- err  out  1  one-cycle pulse: VALID was written with an incomplete span
- dropped  out  1  sticky flag: a span write was ignored while busy; cleared only by reset

## Operation
- The FSM has three states: COLLECT, HOLD and CLEAR. Reset enters COLLECT.
- COLLECT:
  - A write with BASE_ID ≤ wr_id < BASE_ID+SAMPLES stores wr_data into shadow slot k=wr_id−BASE_ID and sets mask[k].
  - Rewriting a slot overwrites it; the last write wins.
- VALID write in COLLECT with mask all ones:
  - The shadow is copied to data_out.
  - mask is cleared.
  - The FSM goes to HOLD.
- VALID write in COLLECT with mask not all ones:
  - err pulses.
  - mask is cleared.
  - data_out is unchanged.
  - The FSM goes to CLEAR, so that the processor's partial writes are released.
- HOLD: data_valid=1. On data_valid & data_ready the FSM goes to CLEAR.
- CLEAR:
  - clr_en=1 for SAMPLES+1 consecutive cycles.
  - clr_id steps BASE_ID, BASE_ID+1, …, BASE_ID+SAMPLES, with the VALID index last.
  - The FSM then returns to COLLECT.
- Any write in span or to VALID while in HOLD or CLEAR is ignored and sets dropped.
- Writes outside BASE_ID..BASE_ID+SAMPLES are ignored in every state.
- Width rules:
  - The offset wr_id−BASE_ID is computed at ID_W bits.
  - The range check is done before slot indexing, so there is no wrap-around aliasing.
  - The clr_id counter is $clog2(SAMPLES+1) bits plus BASE_ID.

## Timing
- Reset values:
  - data_out=0, data_valid=0, clr_en=0, clr_id=0, err=0, dropped=0.
  - mask=0 and state COLLECT.
- Reset asserted mid-HOLD or mid-CLEAR aborts immediately to the reset values. No further clr pulses are issued.
- A word write at cycle N is visible in the shadow at N+1. A VALID write on the same cycle as the final data write is impossible, because there is a single write port.
- A complete VALID write at cycle N gives data_valid=1 and the new data_out from N+1.
- A handshake at cycle M gives data_valid=0 at M+1. clr_en is high over M+1..M+1+SAMPLES, and the FSM is in COLLECT at M+2+SAMPLES.
- An incomplete VALID write at cycle N gives:
  - err=1 at N+1;
  - clr_en high over N+1..N+1+SAMPLES.
- data_ready is a don't-care outside HOLD. data_out is stable for the entire HOLD.
- A write arriving in the last CLEAR cycle counts as busy: it is dropped.
- A write arriving on the first COLLECT cycle is accepted.

## Structure
- Add a state enum typedef (COLLECT/HOLD/CLEAR) to mem_layout_pkg.
- Instance parameters are taken from mem_layout_pkg macros (SDC_*, CHAN_MUX_*, PS_SEED_*). No literals appear at instantiation.
- The block is a single flat module with no sub-module. The clear sequencer is a counter inside the FSM.

## Test plan
- Full SDC span, stalled consumer:
  - Stimulus: write ids 33..48 with data 0x1000+k, then id 49; hold data_ready=0 for 5 cycles, then assert it.
  - Required: data_out[k*16+:16]=0x1000+k, with data_valid stable for 5 cycles.
  - Required: after the handshake, 17 clr pulses with ids 33..49 in order.
- Incomplete span:
  - Stimulus: write ids 33..47 only, then 49.
  - Required: err pulses once.
  - Required: data_out remains 0, data_valid is never asserted, and 17 clr pulses follow.
- Overwrite:
  - Stimulus: write id 40 with 0xAAAA then 0x5555, then complete the span and write VALID.
  - Required: slot 7 reads 0x5555.
- Busy drop:
  - Stimulus: while in HOLD, write id 35 with 0xFFFF.
  - Required: dropped=1; the next assembled word does not contain 0xFFFF unless slot 2 is rewritten.
- Reset mid-CLEAR:
  - Stimulus: assert rst_n=0 on the 5th clr pulse.
  - Required: all outputs are 0 on the next edge; after release, a fresh full span assembles correctly.
- CHAN_MUX instance (BASE_ID=30, SAMPLES=2):
  - Stimulus: write 30=0x3210, 31=0x7654, 32=1.
  - Required: data_out=0x7654_3210; the clr sequence is 30, 31, 32.
